// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, ALU-op classes and the control word
// carried through the ID/EX, EX/MEM and MEM/WB pipeline latches.
package cpu_pkg;

    localparam int OP_W    = 6;
    localparam int ALUOP_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ORI   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_write;
        logic   mem_read;
        aluop_e alu_op;
        logic   branch;
        logic   jump;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    function automatic ctrl_word_t make_ctrl(
        input logic   reg_dst,
        input logic   alu_src,
        input logic   mem_to_reg,
        input logic   reg_write,
        input logic   mem_write,
        input logic   mem_read,
        input aluop_e alu_op,
        input logic   branch,
        input logic   jump
    );
        ctrl_word_t c;
        c.reg_dst    = reg_dst;
        c.alu_src    = alu_src;
        c.mem_to_reg = mem_to_reg;
        c.reg_write  = reg_write;
        c.mem_write  = mem_write;
        c.mem_read   = mem_read;
        c.alu_op     = alu_op;
        c.branch     = branch;
        c.jump       = jump;
        return c;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode decoder: maps an opcode to its control word and
// flags anything outside the decode table as illegal.
module control_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_word_t      ctrl_o,
    output logic            illegal_o
);

    always_comb begin
        ctrl_o    = CTRL_NOP;
        illegal_o = 1'b0;
        // Plain case: X/Z opcodes match no item and fall into the illegal default.
        case (op_i)
            OP_RTYPE: ctrl_o = make_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_FUNCT, 1'b0, 1'b0);
            OP_ADDI:  ctrl_o = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ADD,   1'b0, 1'b0);
            OP_ORI:   ctrl_o = make_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALUOP_ORI,   1'b0, 1'b0);
            OP_LW:    ctrl_o = make_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, ALUOP_ADD,   1'b0, 1'b0);
            OP_SW:    ctrl_o = make_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_ADD,   1'b0, 1'b0);
            OP_BEQ:   ctrl_o = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_SUB,   1'b1, 1'b0);
            OP_J:     ctrl_o = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_ADD,   1'b0, 1'b1);
            default: begin
                ctrl_o    = CTRL_NOP;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage main control: decodes the opcode and registers the control word as
// the control half of the ID/EX latch, with a bubble mux for hazard NOPs.
module control_unit
    import cpu_pkg::*;
#(
    parameter int OP_W    = cpu_pkg::OP_W,
    parameter int ALUOP_W = cpu_pkg::ALUOP_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               bubble_i,
    output logic               reg_dst_o,
    output logic               alu_src_o,
    output logic               mem_to_reg_o,
    output logic               reg_write_o,
    output logic               mem_write_o,
    output logic               mem_read_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               branch_o,
    output logic               jump_o,
    output logic               illegal_o
);

    ctrl_word_t dec_ctrl;
    logic       dec_illegal;
    ctrl_word_t ctrl_d, ctrl_q;
    logic       illegal_d, illegal_q;

    control_decode u_decode (
        .op_i      (op_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    // A bubble overrides the decoded word, including the illegal flag.
    always_comb begin
        ctrl_d    = dec_ctrl;
        illegal_d = dec_illegal;
        if (bubble_i) begin
            ctrl_d    = CTRL_NOP;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q    <= CTRL_NOP;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign reg_dst_o    = ctrl_q.reg_dst;
    assign alu_src_o    = ctrl_q.alu_src;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_write_o  = ctrl_q.mem_write;
    assign mem_read_o   = ctrl_q.mem_read;
    assign alu_op_o     = ctrl_q.alu_op;
    assign branch_o     = ctrl_q.branch;
    assign jump_o       = ctrl_q.jump;
    assign illegal_o    = illegal_q;

    a_br_jmp_excl: assert property (@(posedge clk_i) !(branch_o && jump_o));
    a_mem_rw_excl: assert property (@(posedge clk_i) !(mem_read_o && mem_write_o));
    a_illegal_nop: assert property (@(posedge clk_i) illegal_o |-> (ctrl_q == CTRL_NOP));

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit with hand-written async-reset and bubble sequences.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       bubble;
    logic       reg_dst, alu_src, mem_to_reg, reg_write, mem_write, mem_read;
    logic [1:0] alu_op;
    logic       branch, jump, illegal;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    control_unit #(.OP_W(6), .ALUOP_W(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .op_i         (op),
        .bubble_i     (bubble),
        .reg_dst_o    (reg_dst),
        .alu_src_o    (alu_src),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .mem_write_o  (mem_write),
        .mem_read_o   (mem_read),
        .alu_op_o     (alu_op),
        .branch_o     (branch),
        .jump_o       (jump),
        .illegal_o    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word order: reg_dst,alu_src,mem_to_reg,reg_write,mem_write,mem_read,alu_op[1:0],branch,jump
    localparam logic [9:0] W_NOP = 10'b0000000000;
    localparam logic [9:0] W_R   = 10'b1001001000;
    localparam logic [9:0] W_ADD = 10'b0101000000;
    localparam logic [9:0] W_ORI = 10'b0101001100;
    localparam logic [9:0] W_LW  = 10'b0111010000;
    localparam logic [9:0] W_SW  = 10'b0100100000;
    localparam logic [9:0] W_BEQ = 10'b0000000110;
    localparam logic [9:0] W_J   = 10'b0000000001;

    typedef struct {
        string      name;
        logic       bubble;
        logic [5:0] op;
        logic [9:0] exp_word;
        logic       exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] out_word();
        return {reg_dst, alu_src, mem_to_reg, reg_write, mem_write, mem_read,
                alu_op, branch, jump};
    endfunction

    task automatic check(input string name, input logic [9:0] act_w, input logic act_i,
                         input logic [9:0] exp_w, input logic exp_i);
        n_checks++;
        if (act_w === exp_w && act_i === exp_i) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got word=%b illegal=%b, expected word=%b illegal=%b",
                     name, act_w, act_i, exp_w, exp_i);
        end
    endtask

    task automatic step(input logic b, input logic [5:0] o);
        bubble = b;
        op     = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        op     = 6'b000000;
        bubble = 1'b0;

        vecs.push_back('{"beq",        1'b0, 6'b000100, W_BEQ, 1'b0});
        vecs.push_back('{"lw",         1'b0, 6'b100011, W_LW,  1'b0});
        vecs.push_back('{"sw",         1'b0, 6'b101011, W_SW,  1'b0});
        vecs.push_back('{"rtype",      1'b0, 6'b000000, W_R,   1'b0});
        vecs.push_back('{"j",          1'b0, 6'b000010, W_J,   1'b0});
        vecs.push_back('{"addi",       1'b0, 6'b001000, W_ADD, 1'b0});
        vecs.push_back('{"ori",        1'b0, 6'b001101, W_ORI, 1'b0});
        vecs.push_back('{"ill_3f",     1'b0, 6'b111111, W_NOP, 1'b1});
        vecs.push_back('{"ill_01",     1'b0, 6'b000001, W_NOP, 1'b1});
        vecs.push_back('{"ill_0c",     1'b0, 6'b001100, W_NOP, 1'b1});
        vecs.push_back('{"ill_23x",    1'b0, 6'b100111, W_NOP, 1'b1});
        vecs.push_back('{"bub_ill",    1'b1, 6'b111111, W_NOP, 1'b0});
        vecs.push_back('{"bub_r",      1'b1, 6'b000000, W_NOP, 1'b0});
        vecs.push_back('{"ill_2b_x",   1'b0, 6'b101010, W_NOP, 1'b1});
        vecs.push_back('{"beq_again",  1'b0, 6'b000100, W_BEQ, 1'b0});

        // Reset asserted before any clock edge must clear outputs immediately.
        #2 rst = 1'b1;
        #1 check("reset_pre_edge", out_word(), illegal, W_NOP, 1'b0);
        step(1'b0, 6'b000000);
        check("reset_edge1", out_word(), illegal, W_NOP, 1'b0);
        step(1'b0, 6'b100011);
        check("reset_edge2", out_word(), illegal, W_NOP, 1'b0);

        // Release reset mid-cycle: output stays NOP until the next rising edge.
        #2 rst = 1'b0;
        op = 6'b100011;
        #1 check("rst_release_hold", out_word(), illegal, W_NOP, 1'b0);
        @(posedge clk);
        #1 check("first_lw", out_word(), illegal, W_LW, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].bubble, vecs[i].op);
            check(vecs[i].name, out_word(), illegal, vecs[i].exp_word, vecs[i].exp_ill);
        end

        // Bubble over lw, then the lw word one edge after bubble drops.
        step(1'b1, 6'b100011);
        check("bubble_lw", out_word(), illegal, W_NOP, 1'b0);
        step(1'b0, 6'b100011);
        check("lw_after_bubble", out_word(), illegal, W_LW, 1'b0);

        // Illegal opcode, then async reset mid-cycle clears without an edge.
        step(1'b0, 6'b111111);
        check("illegal_pre_rst", out_word(), illegal, W_NOP, 1'b1);
        step(1'b0, 6'b000000);
        check("rtype_pre_rst", out_word(), illegal, W_R, 1'b0);
        #2 rst = 1'b1;
        #1 check("async_rst_mid", out_word(), illegal, W_NOP, 1'b0);
        @(posedge clk);
        #1 check("async_rst_held", out_word(), illegal, W_NOP, 1'b0);
        rst = 1'b0;
        step(1'b0, 6'b000010);
        check("j_after_rst", out_word(), illegal, W_J, 1'b0);

        // Output holds between edges.
        #3 check("hold_mid_cycle", out_word(), illegal, W_J, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
